// File: rtl/kl_ucb_pkg.sv
// Shared types for the KL-UCB arm dispatcher.
// fp32 aliases, constants and the dispatcher state encoding.
package kl_ucb_pkg;

  typedef logic [31:0] fp32_t;

  localparam fp32_t FP32_ONE  = 32'h3F80_0000;
  localparam fp32_t FP32_ZERO = 32'h0000_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL,
    S_ISSUE,
    S_GAP,
    S_DONE
  } state_e;

  // q is non-negative fp32, so the raw bit pattern orders like the value.
  function automatic logic fp32_pos_gt(fp32_t a, fp32_t b);
    return a > b;
  endfunction

endpackage

// File: rtl/kl_arm_prio_enc.sv
// Finds the lowest enabled arm index >= cur.
// mask_i/cur_i in; idx_o (valid when found_o) out.
module kl_arm_prio_enc #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic [N-1:0]  mask_i,
  input  logic [IW:0]   cur_i,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  localparam int CW = IW + 1;

  // Scan high to low so the last hit, the lowest index, wins.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask_i[i] && (CW'(i) >= cur_i)) begin
        idx_o   = IW'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/kl_ucb_arm_dispatcher.sv
// Sweeps enabled arms through the KL-UCB q engine, tracks the best q.
// Ports: table write (tbl_wr_*), start/arm_mask, engine req (p,d,valid_p/d),
// engine resp (q_final,valid_q_final), status (busy,done,best_*,timeout_err),
// readback (rd_idx -> rd_q).
module kl_ucb_arm_dispatcher
  import kl_ucb_pkg::*;
#(
  parameter int NUM_ARMS = 8,
  parameter int IDX_W    = 3,
  parameter int TIMEOUT  = 1023,
  parameter int GAP      = 2
) (
  input  logic                s_aclk,
  input  logic                s_aresetn,
  input  logic                tbl_wr_en,
  input  logic [IDX_W-1:0]    tbl_wr_idx,
  input  logic [31:0]         tbl_wr_p,
  input  logic [31:0]         tbl_wr_d,
  output logic                tbl_wr_rdy,
  input  logic                start,
  input  logic [NUM_ARMS-1:0] arm_mask,
  output logic [31:0]         p,
  output logic [31:0]         d,
  output logic                valid_p,
  output logic                valid_d,
  input  logic [31:0]         q_final,
  input  logic                valid_q_final,
  output logic                busy,
  output logic                done,
  output logic                best_valid,
  output logic [IDX_W-1:0]    best_arm,
  output logic [31:0]         best_q,
  output logic                timeout_err,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic [31:0]         rd_q
);

  // cur carries one extra bit so it can step past the last arm.
  localparam int CW  = IDX_W + 1;
  localparam int WCW = $clog2(TIMEOUT + 1);
  localparam int GCW = $clog2(GAP + 1);

  state_e state_q, state_d;

  logic [NUM_ARMS-1:0] mask_q, mask_d;
  logic [CW-1:0]       cur_q, cur_d;
  logic [WCW-1:0]      wcnt_q, wcnt_d;
  logic [GCW-1:0]      gcnt_q, gcnt_d;

  fp32_t p_q, p_d;
  fp32_t d_q, d_d;
  fp32_t bq_q, bq_d;

  logic [IDX_W-1:0] barm_q, barm_d;
  logic             bv_q, bv_d;
  logic             terr_q, terr_d;

  fp32_t tbl_p_q [NUM_ARMS];
  fp32_t tbl_d_q [NUM_ARMS];
  fp32_t qst_q   [NUM_ARMS];

  logic             tbl_we;
  logic             qst_we;
  fp32_t            qst_wd;
  logic [IDX_W-1:0] cur_idx;
  logic [IDX_W-1:0] nxt_idx;
  logic             found;
  logic             is_idle;

  assign is_idle = (state_q == S_IDLE);
  assign cur_idx = cur_q[IDX_W-1:0];

  kl_arm_prio_enc #(
    .N  (NUM_ARMS),
    .IW (IDX_W)
  ) u_enc (
    .mask_i  (mask_q),
    .cur_i   (cur_q),
    .idx_o   (nxt_idx),
    .found_o (found)
  );

  // Writes are only taken while idle, including the start cycle.
  assign tbl_we = tbl_wr_en && is_idle &&
                  ({1'b0, tbl_wr_idx} < CW'(NUM_ARMS));

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cur_d   = cur_q;
    wcnt_d  = wcnt_q;
    gcnt_d  = gcnt_q;
    p_d     = p_q;
    d_d     = d_q;
    bq_d    = bq_q;
    barm_d  = barm_q;
    bv_d    = bv_q;
    terr_d  = terr_q;
    qst_we  = 1'b0;
    qst_wd  = FP32_ZERO;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SEL;
          mask_d  = arm_mask;
          cur_d   = '0;
          bv_d    = 1'b0;
          terr_d  = 1'b0;
        end
      end
      S_SEL: begin
        if (found) begin
          cur_d   = {1'b0, nxt_idx};
          p_d     = tbl_p_q[nxt_idx];
          d_d     = tbl_d_q[nxt_idx];
          wcnt_d  = '0;
          state_d = S_ISSUE;
        end else begin
          state_d = S_DONE;
        end
      end
      S_ISSUE: begin
        unique case (1'b1)
          valid_q_final: begin
            qst_we  = 1'b1;
            qst_wd  = q_final;
            if (!bv_q || fp32_pos_gt(q_final, bq_q)) begin
              bq_d   = q_final;
              barm_d = cur_idx;
              bv_d   = 1'b1;
            end
            gcnt_d  = '0;
            state_d = S_GAP;
          end
          (wcnt_q == WCW'(TIMEOUT - 1)): begin
            qst_we  = 1'b1;
            qst_wd  = FP32_ZERO;
            terr_d  = 1'b1;
            gcnt_d  = '0;
            state_d = S_GAP;
          end
          default: begin
            wcnt_d = wcnt_q + 1'b1;
          end
        endcase
      end
      S_GAP: begin
        if (gcnt_q == GCW'(GAP - 1)) begin
          cur_d   = cur_q + 1'b1;
          state_d = S_SEL;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      cur_q   <= '0;
      wcnt_q  <= '0;
      gcnt_q  <= '0;
      p_q     <= FP32_ZERO;
      d_q     <= FP32_ZERO;
      bq_q    <= FP32_ZERO;
      barm_q  <= '0;
      bv_q    <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cur_q   <= cur_d;
      wcnt_q  <= wcnt_d;
      gcnt_q  <= gcnt_d;
      p_q     <= p_d;
      d_q     <= d_d;
      bq_q    <= bq_d;
      barm_q  <= barm_d;
      bv_q    <= bv_d;
      terr_q  <= terr_d;
    end
  end

  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      for (int i = 0; i < NUM_ARMS; i++) begin
        tbl_p_q[i] <= FP32_ZERO;
        tbl_d_q[i] <= FP32_ZERO;
      end
    end else if (tbl_we) begin
      tbl_p_q[tbl_wr_idx] <= tbl_wr_p;
      tbl_d_q[tbl_wr_idx] <= tbl_wr_d;
    end
  end

  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      for (int i = 0; i < NUM_ARMS; i++) begin
        qst_q[i] <= FP32_ZERO;
      end
    end else if (qst_we) begin
      qst_q[cur_idx] <= qst_wd;
    end
  end

  assign tbl_wr_rdy  = is_idle;
  assign busy        = !is_idle;
  assign done        = (state_q == S_DONE);
  assign valid_p     = (state_q == S_ISSUE);
  assign valid_d     = (state_q == S_ISSUE);
  assign p           = p_q;
  assign d           = d_q;
  assign best_valid  = bv_q;
  assign best_arm    = barm_q;
  assign best_q      = bq_q;
  assign timeout_err = terr_q;
  assign rd_q        = ({1'b0, rd_idx} < CW'(NUM_ARMS)) ?
                       qst_q[rd_idx] : FP32_ZERO;

endmodule

// File: tb/tb_kl_ucb_arm_dispatcher.sv
// Directed bench for kl_ucb_arm_dispatcher with a fixed-latency engine model.
// Engine: q = p + d/4, 40 cycles after each valid_p rising edge.
module tb_kl_ucb_arm_dispatcher;
  import kl_ucb_pkg::*;

  localparam int LAT = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tbl_wr_en = 1'b0;
  logic [2:0]  tbl_wr_idx = '0;
  logic [31:0] tbl_wr_p = '0;
  logic [31:0] tbl_wr_d = '0;
  logic        tbl_wr_rdy;
  logic        start = 1'b0;
  logic [7:0]  arm_mask = '0;
  logic [31:0] p, d;
  logic        valid_p, valid_d;
  logic [31:0] q_final;
  logic        valid_q_final;
  logic        busy, done, best_valid;
  logic [2:0]  best_arm;
  logic [31:0] best_q;
  logic        timeout_err;
  logic [2:0]  rd_idx = '0;
  logic [31:0] rd_q;

  always #5 clk = ~clk;

  kl_ucb_arm_dispatcher #(
    .NUM_ARMS (8),
    .IDX_W    (3),
    .TIMEOUT  (100),
    .GAP      (2)
  ) dut (
    .s_aclk        (clk),
    .s_aresetn     (rst_n),
    .tbl_wr_en     (tbl_wr_en),
    .tbl_wr_idx    (tbl_wr_idx),
    .tbl_wr_p      (tbl_wr_p),
    .tbl_wr_d      (tbl_wr_d),
    .tbl_wr_rdy    (tbl_wr_rdy),
    .start         (start),
    .arm_mask      (arm_mask),
    .p             (p),
    .d             (d),
    .valid_p       (valid_p),
    .valid_d       (valid_d),
    .q_final       (q_final),
    .valid_q_final (valid_q_final),
    .busy          (busy),
    .done          (done),
    .best_valid    (best_valid),
    .best_arm      (best_arm),
    .best_q        (best_q),
    .timeout_err   (timeout_err),
    .rd_idx        (rd_idx),
    .rd_q          (rd_q)
  );

  function automatic real f2r(input logic [31:0] b);
    real r;
    int  e;
    if (b[30:0] == 31'h0) return 0.0;
    r = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    return r;
  endfunction

  function automatic logic [31:0] r2f(input real x);
    real         r;
    int          e;
    int          m;
    logic [7:0]  ex;
    logic [22:0] mn;
    if (x <= 0.0) return 32'h0;
    r = x;
    e = 0;
    while (r >= 2.0) begin r = r / 2.0; e++; end
    while (r < 1.0) begin r = r * 2.0; e--; end
    m  = int'((r - 1.0) * 8388608.0);
    ex = 8'(e + 127);
    mn = 23'(m);
    return {1'b0, ex, mn};
  endfunction

  // Engine model
  logic        drop_en = 1'b0;
  logic [31:0] drop_p = '0;
  logic        prev_v;
  logic        pend;
  int          lat;
  logic [31:0] pq;
  int          edges;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_v        <= 1'b0;
      pend          <= 1'b0;
      lat           <= 0;
      pq            <= '0;
      edges         <= 0;
      valid_q_final <= 1'b0;
      q_final       <= '0;
    end else begin
      prev_v        <= valid_p;
      valid_q_final <= 1'b0;
      q_final       <= '0;
      if (valid_p && !prev_v) begin
        edges <= edges + 1;
        if (!(drop_en && p == drop_p)) begin
          pend <= 1'b1;
          lat  <= LAT - 1;
          pq   <= r2f(f2r(p) + f2r(d) / 4.0);
        end
      end else if (pend) begin
        if (lat == 0) begin
          valid_q_final <= 1'b1;
          q_final       <= pq;
          pend          <= 1'b0;
        end else begin
          lat <= lat - 1;
        end
      end
    end
  end

  int done_cnt = 0;
  int hold_cnt = 0;
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (valid_p && drop_en && p == drop_p) hold_cnt++;
  end

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", nm, act, exp);
  endtask

  task automatic chk_rd(input string nm, input int idx,
                        input logic [31:0] exp);
    @(negedge clk);
    rd_idx = 3'(idx);
    #1;
    chk(nm, rd_q, exp);
  endtask

  task automatic tbl_write(input int idx, input logic [31:0] pv,
                           input logic [31:0] dv);
    tbl_wr_en  = 1'b1;
    tbl_wr_idx = 3'(idx);
    tbl_wr_p   = pv;
    tbl_wr_d   = dv;
    @(negedge clk);
    tbl_wr_en  = 1'b0;
  endtask

  task automatic pulse_start(input logic [7:0] m);
    start    = 1'b1;
    arm_mask = m;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_done"}, 32'(done), 32'h1);
    @(negedge clk);
  endtask

  function automatic logic [3:0][31:0] pk4(input logic [31:0] a0,
    input logic [31:0] a1, input logic [31:0] a2, input logic [31:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  typedef struct {
    logic [7:0]       mask;
    logic [3:0][31:0] p;
    logic             bv;
    logic [2:0]       arm;
    logic [31:0]      bq;
    int               edges;
    logic [3:0][31:0] q;
  } vec_t;

  localparam int NV = 5;
  vec_t vec [NV];

  int e0, dc0, h0, n;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0].mask  = 8'h0F;
    vec[0].p     = pk4(32'h3E800000, 32'h3F000000, 32'h3E000000, 32'h0);
    vec[0].bv    = 1'b1;
    vec[0].arm   = 3'd1;
    vec[0].bq    = 32'h3F400000;
    vec[0].edges = 4;
    vec[0].q     = pk4(32'h3F000000, 32'h3F400000, 32'h3EC00000, 32'h3E800000);

    vec[1].mask  = 8'h05;
    vec[1].p     = vec[0].p;
    vec[1].bv    = 1'b1;
    vec[1].arm   = 3'd0;
    vec[1].bq    = 32'h3F000000;
    vec[1].edges = 2;
    vec[1].q     = pk4(32'h3F000000, 32'h3F400000, 32'h3EC00000, 32'h3E800000);

    vec[2].mask  = 8'h0F;
    vec[2].p     = pk4(32'h0, 32'h3E800000, 32'h0, 32'h3E800000);
    vec[2].bv    = 1'b1;
    vec[2].arm   = 3'd1;
    vec[2].bq    = 32'h3F000000;
    vec[2].edges = 4;
    vec[2].q     = pk4(32'h3E800000, 32'h3F000000, 32'h3E800000, 32'h3F000000);

    vec[3].mask  = 8'h00;
    vec[3].p     = vec[2].p;
    vec[3].bv    = 1'b0;
    vec[3].arm   = 3'd0;
    vec[3].bq    = 32'h0;
    vec[3].edges = 0;
    vec[3].q     = vec[2].q;

    vec[4].mask  = 8'h88;
    vec[4].p     = vec[0].p;
    vec[4].bv    = 1'b1;
    vec[4].arm   = 3'd3;
    vec[4].bq    = 32'h3E800000;
    vec[4].edges = 2;
    vec[4].q     = pk4(32'h3E800000, 32'h3F000000, 32'h3E800000, 32'h3E800000);

    repeat (3) @(negedge clk);
    #1;
    chk("rst_status", {26'h0, valid_p, valid_d, busy, done, best_valid,
        timeout_err}, 32'h0);
    chk("rst_wr_rdy", 32'(tbl_wr_rdy), 32'h1);
    chk("rst_p", p, 32'h0);
    chk("rst_best_q", best_q, 32'h0);
    chk("rst_rd_q", rd_q, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < NV; v++) begin
      for (int a = 0; a < 4; a++) tbl_write(a, vec[v].p[a], FP32_ONE);
      e0  = edges;
      dc0 = done_cnt;
      pulse_start(vec[v].mask);
      wait_done($sformatf("v%0d", v));
      chk($sformatf("v%0d_edges", v), 32'(edges - e0), 32'(vec[v].edges));
      chk($sformatf("v%0d_done_cnt", v), 32'(done_cnt - dc0), 32'h1);
      chk($sformatf("v%0d_best_valid", v), 32'(best_valid), 32'(vec[v].bv));
      if (vec[v].bv) begin
        chk($sformatf("v%0d_best_arm", v), 32'(best_arm), 32'(vec[v].arm));
        chk($sformatf("v%0d_best_q", v), best_q, vec[v].bq);
      end
      for (int a = 0; a < 4; a++)
        chk_rd($sformatf("v%0d_rd_q%0d", v, a), a, vec[v].q[a]);
    end

    // Empty mask: done exactly two cycles after start.
    @(negedge clk);
    pulse_start(8'h00);
    chk("empty_c1", {30'h0, busy, done}, 32'h2);
    @(negedge clk);
    chk("empty_c2", {30'h0, busy, done}, 32'h3);
    @(negedge clk);

    // Arm 2 never answers.
    tbl_write(0, 32'h3E800000, FP32_ONE);
    tbl_write(1, 32'h3F000000, FP32_ONE);
    tbl_write(2, 32'h3EC00000, FP32_ONE);
    tbl_write(3, 32'h00000000, FP32_ONE);
    drop_en = 1'b1;
    drop_p  = 32'h3EC00000;
    e0  = edges;
    h0  = hold_cnt;
    dc0 = done_cnt;
    pulse_start(8'h0F);
    wait_done("to");
    drop_en = 1'b0;
    chk("to_hold_cycles", 32'(hold_cnt - h0), 32'd100);
    chk("to_edges", 32'(edges - e0), 32'd4);
    chk("to_done_cnt", 32'(done_cnt - dc0), 32'h1);
    chk("to_err", 32'(timeout_err), 32'h1);
    chk("to_best_arm", 32'(best_arm), 32'h1);
    chk("to_best_q", best_q, 32'h3F400000);
    chk_rd("to_rd_q2", 2, 32'h0);
    chk_rd("to_rd_q3", 3, 32'h3E800000);

    // Start clears the sticky error; then reset during arm 1.
    @(negedge clk);
    e0 = edges;
    pulse_start(8'h0F);
    chk("restart_err_clr", {30'h0, busy, timeout_err}, 32'h2);
    n = 0;
    while ((edges - e0) < 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("arm1_reached", 32'((edges - e0) >= 2), 32'h1);
    chk("arm1_p", p, 32'h3F000000);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_status", {26'h0, valid_p, valid_d, busy, done, best_valid,
        timeout_err}, 32'h0);
    chk("mid_rst_p", p, 32'h0);
    rd_idx = 3'd0;
    #1;
    chk("mid_rst_rd_q0", rd_q, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table was cleared; rebuild and sweep from arm 0.
    for (int a = 0; a < 4; a++) tbl_write(a, vec[0].p[a], FP32_ONE);
    e0 = edges;
    pulse_start(8'h0F);
    n = 0;
    while ((edges - e0) < 1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("post_rst_first_p", p, 32'h3E800000);
    chk("busy_wr_rdy", 32'(tbl_wr_rdy), 32'h0);
    tbl_write(3, 32'h3F000000, FP32_ONE);
    wait_done("post_rst");
    chk("post_rst_best_arm", 32'(best_arm), 32'h1);
    chk("post_rst_best_q", best_q, 32'h3F400000);
    chk("post_rst_err", 32'(timeout_err), 32'h0);
    chk_rd("busy_wr_dropped", 3, 32'h3E800000);

    // Write and start in the same cycle.
    @(negedge clk);
    tbl_wr_en  = 1'b1;
    tbl_wr_idx = 3'd0;
    tbl_wr_p   = 32'h3F000000;
    tbl_wr_d   = FP32_ONE;
    start      = 1'b1;
    arm_mask   = 8'h01;
    @(negedge clk);
    tbl_wr_en  = 1'b0;
    start      = 1'b0;
    wait_done("wr_start");
    chk("wr_start_best_arm", 32'(best_arm), 32'h0);
    chk("wr_start_best_q", best_q, 32'h3F400000);
    chk_rd("wr_start_rd_q0", 0, 32'h3F400000);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
